// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream.
//
// The stream starts with a 16-bit word count N (MSB first). N big-endian
// 32-bit words follow and are written to consecutive im addresses starting
// at BASE_ADDR. The core is held in reset through cpu_rst_f until the whole
// image has been written.
//
// Build option: define IMEM_LOADER_CKSUM_EN to expect one trailing checksum
// byte, the 8-bit sum of all data bytes. A mismatch aborts the load.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | out of reset, nothing loaded, core held in reset
// S_HDR_HI | waiting for word-count MSB
// S_HDR_LO | waiting for word-count LSB, then range check
// S_DATA   | collecting the four bytes of the current word
// S_WRITE  | one-cycle im write of the assembled word, stream paused
// S_CKSUM  | waiting for checksum byte (checksum build only)
// S_DONE   | image loaded, core released
// S_ERR    | load aborted, core held in reset

module imem_loader #(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_f,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
`ifdef IMEM_LOADER_CKSUM_EN
    , S_CKSUM = 3'd7
`endif
  } state_t;

  localparam logic [16:0]       MAX_N = 17'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t state_q, state_d;

  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic              byte_ready_q, byte_ready_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_waddr_q, im_waddr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              cpu_rst_f_q, cpu_rst_f_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        xfer;
  logic        start;
  logic        last_word;
  logic [15:0] n_full;

  // A byte moves only when the registered ready is high; no combinational path
  // from byte_valid back to byte_ready.
  assign xfer      = byte_valid & byte_ready_q;
  assign start     = load_start &
                     ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign n_full    = {n_q[15:8], byte_data};
  assign last_word = ((idx_q + 16'd1) == n_q);

  // State register.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; every stream state simply waits while no byte arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (xfer) state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (xfer) begin
          if ({1'b0, n_full} > MAX_N) begin
            state_d = S_ERR;
          end else if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer && (bcnt_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (xfer) state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Header capture, word assembly, word index and running checksum.
  always_comb begin
    n_d    = n_q;
    idx_d  = idx_q;
    bcnt_d = bcnt_q;
    word_d = word_q;
`ifdef IMEM_LOADER_CKSUM_EN
    sum_d  = sum_q;
`endif
    if (start) begin
      n_d    = 16'd0;
      idx_d  = 16'd0;
      bcnt_d = 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_d  = 8'd0;
`endif
    end
    case (state_q)
      S_HDR_HI: begin
        if (xfer) n_d = {byte_data, n_q[7:0]};
      end
      S_HDR_LO: begin
        if (xfer) n_d = n_full;
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[23:0], byte_data};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
          sum_d  = sum_q + byte_data;
`endif
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register once flopped.
  always_comb begin
    byte_ready_d = 1'b0;
    im_we_d      = 1'b0;
    im_waddr_d   = im_waddr_q;
    im_wdata_d   = im_wdata_q;
    cpu_rst_f_d  = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_d)
      S_HDR_HI, S_HDR_LO, S_DATA: begin
        byte_ready_d = 1'b1;
        busy_d       = 1'b1;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        byte_ready_d = 1'b1;
        busy_d       = 1'b1;
      end
`endif
      S_WRITE: begin
        busy_d     = 1'b1;
        im_we_d    = 1'b1;
        im_waddr_d = BASE + ADDR_W'(idx_q);
        im_wdata_d = word_d;
      end
      S_DONE: begin
        done_d      = 1'b1;
        cpu_rst_f_d = 1'b1;
      end
      S_ERR: begin
        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      n_q          <= 16'd0;
      idx_q        <= 16'd0;
      bcnt_q       <= 2'd0;
      word_q       <= 32'd0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q        <= 8'd0;
`endif
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      im_waddr_q   <= '0;
      im_wdata_q   <= 32'd0;
      cpu_rst_f_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      n_q          <= n_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q        <= sum_d;
`endif
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      im_waddr_q   <= im_waddr_d;
      im_wdata_q   <= im_wdata_d;
      cpu_rst_f_q  <= cpu_rst_f_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = im_we_q;
  assign im_waddr   = im_waddr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_rst_f  = cpu_rst_f_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
